alu_cmd_driver: RTL and testbench
=================================

// Module: alu_cmd_driver
// PURPOSE
//  Initiator side of the 32-bit ALU interface: accepts operation requests (op, A, B, tag) over a
//  valid/ready channel and drives F/A/B to an external combinational ALU from registers.
//  Captures Y/Zero/Overflow one cycle later and returns them over a valid/ready response channel.
//  Sits between the datapath/test sequencer and the ALU instance.
// PARAMETERS
//  WIDTH   32  operand/result width; must match the ALU
//  TAG_W   4   request tag width; the tag is echoed unchanged in the response
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       driver can accept a request
//  req_op     in   3       ALU F code
//  req_a      in   WIDTH   operand A
//  req_b      in   WIDTH   operand B
//  req_tag    in   TAG_W   request tag
//  alu_f      out  3       registered F to the ALU
//  alu_a      out  WIDTH   registered A to the ALU
//  alu_b      out  WIDTH   registered B to the ALU
//  alu_y      in   WIDTH   ALU result
//  alu_zero   in   1       ALU zero flag
//  alu_ovf    in   1       ALU overflow flag
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       consumer accepts the response
//  rsp_y      out  WIDTH   captured result (0 on error)
//  rsp_zero   out  1       captured zero flag
//  rsp_ovf    out  1       overflow flag; masked to 0 unless op is ADD (010) or SUB (110)
//  rsp_err    out  1       illegal op (011); ALU was not issued
//  rsp_tag    out  TAG_W   echoed tag
//  ovf_trap   out  1       sticky overflow trap (see CONFIGURATION)
//  trap_clr   in   1       clears ovf_trap
// BEHAVIOUR
//  Legal ops: 000 AND, 001 OR, 010 ADD, 100 AND~B, 101 OR~B, 110 SUB, 111 SLT. 011 is illegal.
//  FSM states:
//   - IDLE: req_ready=1; the request is accepted on the cycle req_valid & req_ready.
//       Legal op  -> latch the request into alu_f/a/b and tag -> EXEC.
//       Illegal op -> rsp_err=1, rsp_y=0, rsp_zero=0, rsp_ovf=0, latch tag -> RESP.
//         The alu_* registers are not changed.
//   - EXEC (1 cycle): capture alu_y/zero/ovf (ovf masked) into rsp_* -> RESP.
//   - RESP: rsp_valid=1. Outputs hold stable until rsp_ready. Handshake -> IDLE.
//  Latency: legal op accepted in cycle N -> rsp_valid in N+2; illegal op -> rsp_valid in N+1.
//  Throughput: at most one request per 3 cycles (legal op, zero backpressure).
//  req_ready=0 in EXEC and RESP. A new request is never accepted in the cycle the response retires.
//  req_* are ignored when req_ready=0. A requester must hold the request until it is accepted.
//  Reset (asynchronous, mid-operation included): state=IDLE and all outputs/registers 0, except req_ready=1.
//   Any in-flight request is dropped with no response.
//  rsp_zero reflects alu_zero as captured; on error it is forced to 0.
// CONFIGURATION
//  ALU_DRV_OVF_TRAP_EN defined:
//   - ovf_trap sets at EXEC capture when the masked overflow is 1, and stays set until trap_clr.
//   - While ovf_trap=1, req_ready=0 in IDLE.
//   - trap_clr and a new set in the same cycle: set wins.
//   - ovf_trap resets to 0.
//  ALU_DRV_OVF_TRAP_EN undefined: ovf_trap tied 0; trap_clr ignored.
// STRUCTURE
//  alu_defs.vh (shared include): F-code localparams OP_AND, OP_OR, OP_ADD, OP_ANDN, OP_ORN, OP_SUB,
//   OP_SLT, OP_ILL; FSM state encodings S_IDLE/S_EXEC/S_RESP.
//  Sub-module alu_op_check (combinational):
//   - op -> legal
//   - op -> ovf_mask (1 only for ADD/SUB)
//  Single FSM plus request and response registers in the top module. No ALU is instantiated inside.
// TESTING
//  Bench instantiates alu_cmd_driver + alu32 back-to-back.
//  1. ADD a=5, b=7, tag=3, rsp_ready=1 -> rsp_valid at N+2, y=12, zero=0, ovf=0, tag=3.
//  2. SUB a=0x7FFFFFFF, b=0xFFFFFFFF -> y=0x80000000, ovf=1. With macro: ovf_trap=1 and req_ready=0
//     until trap_clr pulse.
//  3. SLT a=0xFFFFFFFE (-2), b=1 -> y=1. OR a=0, b=0 -> y=0, zero=1. OR ovf masked to 0 even if
//     alu_ovf=1.
//  4. op=011, tag=9 -> rsp_valid at N+1, err=1, y=0, tag=9. alu_f/a/b unchanged from the prior op.
//  5. Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready=0
//     throughout. Retire -> req_ready=1 next cycle.
//  6. Assert reset while in EXEC -> the same cycle: rsp_valid=0, alu_*=0, req_ready=1. No response
//     for the dropped request after release.

Source files
------------

// File: rtl/alu_cmd_driver_pkg.sv
// rtl/alu_cmd_driver_pkg.sv - ALU F-code and driver FSM state encodings
package alu_cmd_driver_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ILL  = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_ORN  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op != OP_ILL;
    endfunction

endpackage

// File: rtl/alu_cmd_driver_if.sv
// rtl/alu_cmd_driver_if.sv - request, ALU and response channels of the ALU command driver
interface alu_cmd_driver_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       alu_f;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_y;
    logic             alu_zero;
    logic             alu_ovf;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_zero;
    logic             rsp_ovf;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;
    logic             ovf_trap;
    logic             trap_clr;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, rsp_ready, trap_clr,
               alu_y, alu_zero, alu_ovf,
        input  req_ready, alu_f, alu_a, alu_b, rsp_valid, rsp_y, rsp_zero,
               rsp_ovf, rsp_err, rsp_tag, ovf_trap
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready, trap_clr,
               alu_y, alu_zero, alu_ovf,
        output req_ready, alu_f, alu_a, alu_b, rsp_valid, rsp_y, rsp_zero,
               rsp_ovf, rsp_err, rsp_tag, ovf_trap
    );
endinterface

// File: rtl/alu_op_check.sv
// rtl/alu_op_check.sv - classifies an ALU F code as legal and as overflow-relevant
module alu_op_check
    import alu_cmd_driver_pkg::*;
(
    input  logic [2:0] op,
    output logic       legal,
    output logic       ovf_mask
);
    assign legal    = op_is_legal(op);
    // Overflow is only meaningful for the arithmetic ops; SLT's internal subtract is not reported.
    assign ovf_mask = (op == OP_ADD) || (op == OP_SUB);
endmodule

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - registered initiator for an external 32-bit ALU; sticky trap via ALU_DRV_OVF_TRAP_EN
module alu_cmd_driver
    import alu_cmd_driver_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    alu_cmd_driver_if.slave bus
);
    logic [1:0]       state;
    logic [2:0]       f_q;
    logic [WIDTH-1:0] a_q, b_q, y_q;
    logic [TAG_W-1:0] tag_q;
    logic             zero_q, ovf_q, err_q, mask_q, trap_q;
    logic             op_legal, op_ovf_mask, accept, trap_set;

    alu_op_check u_op_check (
        .op       (bus.req_op),
        .legal    (op_legal),
        .ovf_mask (op_ovf_mask)
    );

    assign accept   = bus.req_valid && bus.req_ready;
    assign trap_set = (state == S_EXEC) && mask_q && bus.alu_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            f_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            y_q    <= '0;
            tag_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            mask_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        tag_q <= bus.req_tag;
                        if (op_legal) begin
                            f_q    <= bus.req_op;
                            a_q    <= bus.req_a;
                            b_q    <= bus.req_b;
                            mask_q <= op_ovf_mask;
                            state  <= S_EXEC;
                        end else begin
                            // Illegal op: respond immediately, leave the ALU operands untouched.
                            y_q    <= '0;
                            zero_q <= 1'b0;
                            ovf_q  <= 1'b0;
                            err_q  <= 1'b1;
                            state  <= S_RESP;
                        end
                    end
                end
                S_EXEC: begin
                    y_q    <= bus.alu_y;
                    zero_q <= bus.alu_zero;
                    ovf_q  <= bus.alu_ovf && mask_q;
                    err_q  <= 1'b0;
                    state  <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_DRV_OVF_TRAP_EN
    // Set has priority over a coincident clear so an overflow is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trap_q <= 1'b0;
        end else if (trap_set) begin
            trap_q <= 1'b1;
        end else if (bus.trap_clr) begin
            trap_q <= 1'b0;
        end
    end
`else
    assign trap_q = 1'b0;
    logic unused_trap;
    assign unused_trap = bus.trap_clr ^ trap_set;
`endif

    assign bus.req_ready = (state == S_IDLE) && !trap_q;
    assign bus.alu_f     = f_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_y     = y_q;
    assign bus.rsp_zero  = zero_q;
    assign bus.rsp_ovf   = ovf_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_tag   = tag_q;
    assign bus.ovf_trap  = trap_q;
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - scoreboard bench for alu_cmd_driver with a behavioural ALU
module tb_alu_cmd_driver;
    import alu_cmd_driver_pkg::*;

    typedef struct {
        logic [31:0] y;
        logic        zero;
        logic        ovf;
        logic        err;
        logic [3:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic force_ovf = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    exp_t last;
    logic [2:0]  last_f;
    logic [31:0] last_a, last_b;

    always #5 clk = ~clk;

    alu_cmd_driver_if #(.WIDTH(32), .TAG_W(4)) bus ();

    alu_cmd_driver #(.WIDTH(32), .TAG_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] ref_y(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] bb, s;
        bb = f[2] ? ~b : b;
        s  = a + bb + {31'b0, f[2]};
        case (f[1:0])
            2'b00:   return a & bb;
            2'b01:   return a | bb;
            2'b10:   return s;
            default: return {31'b0, s[31]};
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] bb, s;
        bb = f[2] ? ~b : b;
        s  = a + bb + {31'b0, f[2]};
        return (a[31] == bb[31]) && (s[31] != a[31]);
    endfunction

    assign bus.alu_y    = ref_y(bus.alu_f, bus.alu_a, bus.alu_b);
    assign bus.alu_zero = (bus.alu_y == 32'd0);
    assign bus.alu_ovf  = ref_ovf(bus.alu_f, bus.alu_a, bus.alu_b) | force_ovf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        exp_t e;
        int n;
        if (op != OP_ILL) begin
            e.y    = ref_y(op, a, b);
            e.zero = (e.y == 32'd0);
            e.ovf  = ((op == OP_ADD) || (op == OP_SUB)) && ref_ovf(op, a, b);
            e.err  = 1'b0;
            last_f = op; last_a = a; last_b = b;
        end else begin
            e.y = 32'd0; e.zero = 1'b0; e.ovf = 1'b0; e.err = 1'b1;
        end
        e.tag = tag;
        q.push_back(e);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_timeout", 64'(n < 20), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_op = OP_ADD; bus.req_a = $urandom; bus.req_b = $urandom;
    endtask

    // Called one cycle after acceptance; lat counts cycles from the accept cycle.
    task automatic recv(input int lat, input bit retire, output exp_t e);
        int cnt;
        cnt = 1;
        while (!bus.rsp_valid && cnt < 20) begin
            @(posedge clk); #1; cnt++;
        end
        chk("latency", 64'(cnt), 64'(lat));
        if (q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
            e = last;
        end else begin
            e = q.pop_front();
        end
        chk("rsp_y",    64'(bus.rsp_y),    64'(e.y));
        chk("rsp_zero", 64'(bus.rsp_zero), 64'(e.zero));
        chk("rsp_ovf",  64'(bus.rsp_ovf),  64'(e.ovf));
        chk("rsp_err",  64'(bus.rsp_err),  64'(e.err));
        chk("rsp_tag",  64'(bus.rsp_tag),  64'(e.tag));
        chk("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
        if (retire) begin
            @(posedge clk); #1;
            chk("rsp_valid_retired", 64'(bus.rsp_valid), 64'd0);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
        bus.rsp_ready = 1'b1; bus.trap_clr = 1'b0;
        last_f = '0; last_a = '0; last_b = '0;
        #2 reset = 1'b1;
        #1;
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
        chk("reset_alu_a",     64'(bus.alu_a),     64'd0);
        chk("reset_rsp_y",     64'(bus.rsp_y),     64'd0);
        chk("reset_ovf_trap",  64'(bus.ovf_trap),  64'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // ADD with no backpressure
        send(OP_ADD, 32'd5, 32'd7, 4'd3);
        recv(2, 1'b1, last);
        chk("add_y", 64'(last.y), 64'd12);
        chk("ready_after_add", 64'(bus.req_ready), 64'd1);

        // SUB overflow
        send(OP_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'd5);
        recv(2, 1'b1, last);
        chk("sub_ovf", 64'(last.ovf), 64'd1);
`ifdef ALU_DRV_OVF_TRAP_EN
        chk("trap_set",        64'(bus.ovf_trap),  64'd1);
        chk("trap_blocks_req", 64'(bus.req_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 chk("trap_still_blocks", 64'(bus.req_ready), 64'd0);
        bus.trap_clr = 1'b1;
        @(posedge clk); #1;
        bus.trap_clr = 1'b0;
        chk("trap_cleared", 64'(bus.ovf_trap),  64'd0);
        chk("trap_ready",   64'(bus.req_ready), 64'd1);
`else
        chk("trap_tied_0", 64'(bus.ovf_trap),  64'd0);
        chk("no_trap_ready", 64'(bus.req_ready), 64'd1);
`endif

        // SLT, zero flag, masked overflow on logic op
        send(OP_SLT, 32'hFFFF_FFFE, 32'd1, 4'd6);
        recv(2, 1'b1, last);
        force_ovf = 1'b1;
        send(OP_OR, 32'd0, 32'd0, 4'd7);
        recv(2, 1'b1, last);
        force_ovf = 1'b0;
        send(OP_ANDN, 32'hF0F0_FFFF, 32'h00FF_00F0, 4'd1);
        recv(2, 1'b1, last);
        send(OP_ORN, 32'h1234_0000, 32'hFFFF_0F0F, 4'd2);
        recv(2, 1'b1, last);

        // Illegal op leaves ALU operands from the prior legal op
        send(OP_ILL, 32'hDEAD_BEEF, 32'h1, 4'd9);
        chk("ill_alu_f", 64'(bus.alu_f), 64'(last_f));
        chk("ill_alu_a", 64'(bus.alu_a), 64'(last_a));
        chk("ill_alu_b", 64'(bus.alu_b), 64'(last_b));
        recv(1, 1'b1, last);

        // Backpressure for 5 cycles
        bus.rsp_ready = 1'b0;
        send(OP_ADD, 32'hFFFF_FFFF, 32'd1, 4'd11);
        recv(2, 1'b0, last);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_y",     64'(bus.rsp_y),     64'(last.y));
            chk("bp_tag",   64'(bus.rsp_tag),   64'(last.tag));
            chk("bp_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_retired",    64'(bus.rsp_valid), 64'd0);
        chk("bp_ready_back", 64'(bus.req_ready), 64'd1);

        // Reset while in EXEC drops the request
        send(OP_ADD, 32'd100, 32'd23, 4'd12);
        reset = 1'b1;
        #1;
        chk("rst_exec_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_exec_f",     64'(bus.alu_f),     64'd0);
        chk("rst_exec_a",     64'(bus.alu_a),     64'd0);
        chk("rst_exec_ready", 64'(bus.req_ready), 64'd1);
        void'(q.pop_back());
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("no_dropped_rsp", 64'(bus.rsp_valid), 64'd0);
        end

        send(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd14);
        recv(2, 1'b1, last);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
